pong_match_ctrl: RTL and testbench

Game-flow controller for the VGA pong datapath. It sequences a match through serve, play, miss-pause and game-over, and gates ball motion through an enable and a ball-reset pulse. It also keeps a 4-digit BCD score and a lives count for the 7-segment display driver. Sits between the video timer (frame tick), the game datapath (hit/miss events, ball enable) and the board buttons.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/bcd_counter4.sv | 49 ++++
 rtl/pong_match_ctrl.sv | 150 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: state encoding, BCD digit
// width and default frame counts.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int BCD_W            = 4;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int MISS_FRAMES_DEF  = 63;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter: increment with digit carry, synchronous clear,
// and saturation at 9999.
module bcd_counter4
  import pong_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [4*BCD_W-1:0]   cnt_o
);

  localparam logic [4*BCD_W-1:0] BCD_MAX = 16'h9999;

  logic [4*BCD_W-1:0] cnt_q, cnt_d;

  function automatic logic [4*BCD_W-1:0] bcd_inc(input logic [4*BCD_W-1:0] v);
    logic [4*BCD_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    if (v == BCD_MAX) return v;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*BCD_W +: BCD_W] == 4'd9) begin
          r[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = bcd_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the pong datapath: serve/play/miss/over flow, ball gating,
// lives count and BCD score.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int MISS_FRAMES  = MISS_FRAMES_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        paddle_hit,
  input  logic        ball_miss,
  output logic        ball_run,
  output logic        ball_reset,
  output logic        miss_flash,
  output logic        game_over,
  output logic [1:0]  lives,
  output logic [15:0] score_bcd,
  output logic [2:0]  state_out
);

  localparam int CNT_W = max_i(6, $clog2(max_i(SERVE_FRAMES, MISS_FRAMES) + 1));
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_FRAMES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_prev_q;
  logic                   start_pulse;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lives_q, lives_d;
  logic             ball_run_q, ball_reset_q, miss_flash_q, game_over_q;
  logic             restart, reload;
  logic             score_inc;

  // Two-flop synchronizer, then rising edge so a held button starts only once.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], start_btn};
      btn_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign start_pulse = sync_q[SYNC_STAGES-1] & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    restart = 1'b0;
    reload  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) restart = 1'b1;
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (ball_miss) begin
          state_d = ST_MISS;
          lives_d = lives_q - 2'd1;
          cnt_d   = '0;
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (cnt_q == MISS_LAST) begin
            cnt_d = '0;
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
              reload  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_pulse) restart = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (restart) begin
      state_d = ST_SERVE;
      lives_d = LIVES_INIT;
      cnt_d   = '0;
    end
  end

  assign score_inc = (state_q == ST_PLAY) && paddle_hit;

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lives_q      <= LIVES_INIT;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      miss_flash_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      ball_run_q   <= (state_d == ST_PLAY);
      ball_reset_q <= restart | reload;
      miss_flash_q <= (state_d == ST_MISS);
      game_over_q  <= (state_d == ST_OVER);
    end
  end

  bcd_counter4 u_score (
    .clk   (clk25),
    .rst_n (reset),
    .clr_i (restart),
    .inc_i (score_inc),
    .cnt_o (score_bcd)
  );

  assign ball_run   = ball_run_q;
  assign ball_reset = ball_reset_q;
  assign miss_flash = miss_flash_q;
  assign game_over  = game_over_q;
  assign lives      = lives_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: vector table for scoring in PLAY plus
// hand-written sequences for start, serve, miss, game-over and reset.
module tb_pong_match_ctrl;

  logic        clk25 = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        paddle_hit = 1'b0;
  logic        ball_miss = 1'b0;
  logic        ball_run, ball_reset, miss_flash, game_over;
  logic [1:0]  lives;
  logic [15:0] score_bcd;
  logic [2:0]  state_out;

  int errors = 0;
  int checks = 0;

  pong_match_ctrl dut (
    .clk25      (clk25),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .paddle_hit (paddle_hit),
    .ball_miss  (ball_miss),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .miss_flash (miss_flash),
    .game_over  (game_over),
    .lives      (lives),
    .score_bcd  (score_bcd),
    .state_out  (state_out)
  );

  always #20 clk25 = ~clk25;

  typedef struct {
    logic        hit;
    logic        miss;
    logic        tick;
    logic [15:0] score;
    logic [2:0]  st;
    logic        run;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs set on the falling edge, outputs settled #1 after the rising edge.
  task automatic cyc(input logic h, input logic m, input logic t, input logic b);
    @(negedge clk25);
    paddle_hit = h;
    ball_miss  = m;
    frame_tick = t;
    start_btn  = b;
    @(posedge clk25);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic press(input int hold, output int pulses);
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      cyc(0, 0, 0, 1);
      if (ball_reset) pulses++;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      if (ball_reset) pulses++;
    end
  endtask

  int np;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 3'd2, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0002, 3'd2, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 3'd2, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 3'd2, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 3'd2, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0006, 3'd2, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0007, 3'd2, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0008, 3'd2, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0009, 3'd2, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 3'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0010, 3'd2, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0011, 3'd2, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0012, 3'd2, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0013, 3'd2, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h0014, 3'd2, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 16'h0015, 3'd2, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16'h0016, 3'd2, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 16'h0017, 3'd2, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 16'h0018, 3'd2, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 16'h0019, 3'd2, 1'b1};

    // Reset state
    repeat (3) @(posedge clk25);
    #1;
    chk("rst_state", state_out, 3'd0);
    chk("rst_lives", lives, 2'd3);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_run", ball_run, 1'b0);
    chk("rst_breset", ball_reset, 1'b0);
    chk("rst_flash", miss_flash, 1'b0);
    chk("rst_over", game_over, 1'b0);
    @(negedge clk25);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // Held start button: exactly one ball_reset pulse
    press(1000, np);
    chk("start_pulses", np, 1);
    chk("start_state", state_out, 3'd1);
    chk("start_lives", lives, 2'd3);
    chk("start_run", ball_run, 1'b0);

    frames(59);
    chk("serve59_state", state_out, 3'd1);
    cyc(0, 0, 1, 0);
    chk("serve60_state", state_out, 3'd2);
    chk("serve60_run", ball_run, 1'b1);

    // Scoring vectors in PLAY
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].hit, tbl[i].miss, tbl[i].tick, 1'b0);
      chk($sformatf("vec%0d_score", i), score_bcd, tbl[i].score);
      chk($sformatf("vec%0d_state", i), state_out, tbl[i].st);
      chk($sformatf("vec%0d_run", i), ball_run, tbl[i].run);
    end

    for (int i = 0; i < 80; i++) cyc(1, 0, 0, 0);
    chk("score_0099", score_bcd, 16'h0099);

    // Simultaneous hit and miss
    cyc(1, 1, 0, 0);
    chk("hm_score", score_bcd, 16'h0100);
    chk("hm_lives", lives, 2'd2);
    chk("hm_state", state_out, 3'd3);
    chk("hm_flash", miss_flash, 1'b1);
    chk("hm_run", ball_run, 1'b0);

    // Events injected during MISS are ignored
    frames(30);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    press(5, np);
    frames(32);
    chk("miss62_state", state_out, 3'd3);
    chk("miss62_score", score_bcd, 16'h0100);
    chk("miss62_lives", lives, 2'd2);
    cyc(0, 0, 1, 0);
    chk("miss63_state", state_out, 3'd1);
    chk("miss63_breset", ball_reset, 1'b1);
    chk("miss63_flash", miss_flash, 1'b0);
    cyc(0, 0, 0, 0);
    chk("breset_1cyc", ball_reset, 1'b0);

    // Events injected during SERVE are ignored
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    press(5, np);
    chk("serve_inj_pulses", np, 0);
    frames(59);
    chk("serve_inj_state", state_out, 3'd1);
    chk("serve_inj_score", score_bcd, 16'h0100);
    chk("serve_inj_lives", lives, 2'd2);
    cyc(0, 0, 1, 0);
    chk("serve_inj_play", state_out, 3'd2);

    // Remaining misses to game over
    cyc(0, 1, 0, 0);
    chk("miss2_lives", lives, 2'd1);
    frames(63);
    frames(60);
    chk("play3_state", state_out, 3'd2);
    cyc(0, 1, 0, 0);
    chk("miss3_lives", lives, 2'd0);
    frames(63);
    chk("over_state", state_out, 3'd4);
    chk("over_flag", game_over, 1'b1);
    chk("over_lives", lives, 2'd0);
    chk("over_score", score_bcd, 16'h0100);
    chk("over_run", ball_run, 1'b0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("over_hold_score", score_bcd, 16'h0100);
    chk("over_hold_state", state_out, 3'd4);

    // Restart from OVER
    press(20, np);
    chk("restart_pulses", np, 1);
    chk("restart_state", state_out, 3'd1);
    chk("restart_score", score_bcd, 16'h0000);
    chk("restart_lives", lives, 2'd3);
    chk("restart_over", game_over, 1'b0);

    // Asynchronous reset mid-PLAY with score 0x0042
    frames(60);
    for (int i = 0; i < 42; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_rst_score", score_bcd, 16'h0042);
    @(posedge clk25);
    #7;
    reset = 1'b0;
    #1;
    chk("arst_state", state_out, 3'd0);
    chk("arst_score", score_bcd, 16'h0000);
    chk("arst_run", ball_run, 1'b0);
    chk("arst_lives", lives, 2'd3);
    @(negedge clk25);
    reset = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);
    chk("post_rst_state", state_out, 3'd0);
    chk("post_rst_lives", lives, 2'd3);

    // Carry across digits and saturation at 9999
    press(10, np);
    frames(60);
    for (int i = 0; i < 999; i++) cyc(1, 0, 0, 0);
    chk("score_0999", score_bcd, 16'h0999);
    cyc(1, 0, 0, 0);
    chk("score_1000", score_bcd, 16'h1000);
    for (int i = 0; i < 8999; i++) cyc(1, 0, 0, 0);
    chk("score_9999", score_bcd, 16'h9999);
    cyc(1, 0, 0, 0);
    chk("score_sat", score_bcd, 16'h9999);
    chk("sat_state", state_out, 3'd2);
    cyc(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
